cs_avg_resolve: RTL and testbench

//  Downstream stage of the 8-operand carry-save compressor in the demosaic datapath.

---
 rtl/demosaic_pkg.sv | 16 +
 rtl/cs_avg_resolve_if.sv | 29 ++
 rtl/cs_avg_resolve_pipe_reg_vr.sv | 46 ++++
 rtl/cs_avg_resolve.sv | 100 ++++++++++
 tb/tb_cs_avg_resolve.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/demosaic_pkg.sv
// Shared widths and the round-half-up averaging helper for the demosaic datapath.
package demosaic_pkg;

  localparam int PIX_W = 8;
  localparam int CS_W  = 11;
  localparam int SUM_W = CS_W + 1;

  // Adds half an LSB of the result, then shifts; sh must be at least 1.
  function automatic logic [SUM_W-1:0] rnd_shift(input logic [SUM_W-1:0] sum,
                                                 input int unsigned      sh);
    logic [SUM_W-1:0] biased;
    biased = sum + (SUM_W'(1) << (sh - 1));
    return biased >> sh;
  endfunction

endpackage

// File: rtl/cs_avg_resolve_if.sv
// Valid/ready stream bundle for cs_avg_resolve: carry-save beats in, averaged pixels out.
interface cs_avg_resolve_if
  import demosaic_pkg::*;
#(
  parameter int IN_W  = CS_W,
  parameter int OUT_W = PIX_W
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_cs1;
  logic [IN_W-1:0]  in_cs2;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_pix;
  logic             out_last;

  modport master (
    output in_valid, in_cs1, in_cs2, in_last, out_ready,
    input  in_ready, out_valid, out_pix, out_last
  );

  modport slave (
    input  in_valid, in_cs1, in_cs2, in_last, out_ready,
    output in_ready, out_valid, out_pix, out_last
  );

endinterface

// File: rtl/cs_avg_resolve_pipe_reg_vr.sv
// One valid/ready register slice: loads when empty or when its content leaves this cycle.
module pipe_reg_vr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         take;
  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;

  // NOTE: every always_comb output gets a hold default first so no latch is inferred.
  always_comb begin
    take   = !v_q || out_ready;
    v_d    = v_q;
    data_d = data_q;
    if (take) begin
      v_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // NOTE: state updates use <= so all flops sample pre-edge values together.
  // NOTE: payload is reset too, because the visible output must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = take;
  assign out_valid = v_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cs_avg_resolve.sv
// Resolves two carry-save vectors with a split 2-stage add, then averages, rounds and
// saturates to one pixel per beat; counts saturated beats.
module cs_avg_resolve
  import demosaic_pkg::*;
#(
  parameter int          IN_W  = CS_W,
  parameter int          OUT_W = PIX_W,
  parameter int unsigned SHIFT = 3,
  parameter int          SPLIT = 6
) (
  input  logic              clk,
  input  logic              rst,
  cs_avg_resolve_if.slave   bus,
  input  logic              sat_clr,
  output logic [15:0]       sat_cnt
);

  localparam int HI_W = IN_W - SPLIT;

  typedef struct packed {
    logic            last;
    logic [HI_W-1:0] hi2;
    logic [HI_W-1:0] hi1;
    logic [SPLIT:0]  lo;
  } s1_t;

  typedef struct packed {
    logic             last;
    logic [OUT_W-1:0] pix;
  } s2_t;

  s1_t s1_in, s1_out;
  s2_t s2_in, s2_out;
  logic s1_valid, s2_in_ready, s2_load;

  logic [HI_W:0]  hi_sum;
  logic [IN_W:0]  sum, r;
  logic           sat;
  logic [15:0]    sat_cnt_q, sat_cnt_d;

  // Low half resolved before S1; its carry-out rides along in lo[SPLIT].
  always_comb begin
    s1_in.last = bus.in_last;
    s1_in.hi1  = bus.in_cs1[IN_W-1:SPLIT];
    s1_in.hi2  = bus.in_cs2[IN_W-1:SPLIT];
    s1_in.lo   = {1'b0, bus.in_cs1[SPLIT-1:0]} + {1'b0, bus.in_cs2[SPLIT-1:0]};
  end

  always_comb begin
    hi_sum     = (HI_W+1)'(s1_out.hi1) + (HI_W+1)'(s1_out.hi2) + (HI_W+1)'(s1_out.lo[SPLIT]);
    sum        = {hi_sum, s1_out.lo[SPLIT-1:0]};
    r          = (IN_W+1)'(rnd_shift(SUM_W'(sum), SHIFT));
    sat        = r > (IN_W+1)'((1 << OUT_W) - 1);
    s2_in.last = s1_out.last;
    s2_in.pix  = sat ? '1 : r[OUT_W-1:0];
  end

  pipe_reg_vr #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_out)
  );

  pipe_reg_vr #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_out)
  );

  assign bus.out_pix  = s2_out.pix;
  assign bus.out_last = s2_out.last;

  assign s2_load = s1_valid && s2_in_ready;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (s2_load && sat && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_cs_avg_resolve.sv
// Bench for cs_avg_resolve: SHIFT=3 and SHIFT=2 instances, vector tables, stall and
// reset sequences, and a randomized stream against an arithmetic reference.
module tb_cs_avg_resolve;
  import demosaic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_clr3, sat_clr2;
  logic [15:0] sat_cnt3, sat_cnt2;

  always #5 clk = ~clk;

  cs_avg_resolve_if bus3 ();
  cs_avg_resolve_if bus2 ();

  cs_avg_resolve #(.SHIFT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .sat_clr(sat_clr3), .sat_cnt(sat_cnt3)
  );

  cs_avg_resolve #(.SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .sat_clr(sat_clr2), .sat_cnt(sat_cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Average of the true operand sum, half rounded up, clipped to the pixel range.
  function automatic int ref_pix(input int total, input int sh);
    int r;
    r = (total + (1 << (sh - 1))) / (1 << sh);
    return (r > 255) ? 255 : r;
  endfunction

  typedef struct {
    logic [10:0] cs1;
    logic [10:0] cs2;
    bit          last;
    bit          clr;
    int          pix;
    int          cnt;
  } vec_t;

  vec_t t3[8];
  vec_t t2[6];

  task automatic beat3(input vec_t v, input string tag);
    @(negedge clk);
    bus3.in_valid  = 1'b1;
    bus3.in_cs1    = v.cs1;
    bus3.in_cs2    = v.cs2;
    bus3.in_last   = v.last;
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    sat_clr3      = v.clr;
    check({tag, "_valid_early"}, int'(bus3.out_valid), 0);
    @(posedge clk); #1;
    sat_clr3 = 1'b0;
    check({tag, "_valid"}, int'(bus3.out_valid), 1);
    check({tag, "_pix"},   int'(bus3.out_pix),   v.pix);
    check({tag, "_last"},  int'(bus3.out_last),  int'(v.last));
    check({tag, "_satcnt"}, int'(sat_cnt3),      v.cnt);
  endtask

  task automatic beat2(input vec_t v, input string tag);
    @(negedge clk);
    bus2.in_valid  = 1'b1;
    bus2.in_cs1    = v.cs1;
    bus2.in_cs2    = v.cs2;
    bus2.in_last   = v.last;
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    sat_clr2      = v.clr;
    check({tag, "_valid_early"}, int'(bus2.out_valid), 0);
    @(posedge clk); #1;
    sat_clr2 = 1'b0;
    check({tag, "_valid"}, int'(bus2.out_valid), 1);
    check({tag, "_pix"},   int'(bus2.out_pix),   v.pix);
    check({tag, "_last"},  int'(bus2.out_last),  int'(v.last));
    check({tag, "_satcnt"}, int'(sat_cnt2),      v.cnt);
  endtask

  // Streams beats into dut3 with either a fixed out_ready stall window or random
  // valid/ready, comparing every delivered beat and stalled-output stability.
  task automatic run_stream(input int nbeats, input bit rnd, input int stall_lo,
                            input int stall_hi, input int budget, input string tag,
                            output int blocked, output int buffered);
    logic [10:0] c1q[$];
    logic [10:0] c2q[$];
    bit          lq[$];
    int          epix[$];
    int          sent, got, cyc, a, b, hpix, hlast;
    bit          hold;
    for (int i = 0; i < nbeats; i++) begin
      if (rnd) begin
        a = int'($urandom_range(0, 2040));
        b = int'($urandom_range(0, 2040 - a));
        lq.push_back(bit'($urandom_range(0, 1)));
      end else begin
        a = 100 * i + 7;
        b = 3 * i + 1;
        lq.push_back(i == nbeats - 1);
      end
      c1q.push_back(11'(a));
      c2q.push_back(11'(b));
      epix.push_back(ref_pix(a + b, 3));
    end
    sent = 0; got = 0; cyc = 0; hold = 1'b0; hpix = 0; hlast = 0;
    blocked = 0; buffered = -1;
    while (got < nbeats && cyc < budget) begin
      @(negedge clk);
      if (hold) begin
        check({tag, "_hold_valid"}, int'(bus3.out_valid), 1);
        check({tag, "_hold_pix"},   int'(bus3.out_pix),   hpix);
        check({tag, "_hold_last"},  int'(bus3.out_last),  hlast);
      end
      bus3.in_valid = (sent < nbeats) && (!rnd || $urandom_range(0, 3) != 0);
      if (sent < nbeats) begin
        bus3.in_cs1  = c1q[sent];
        bus3.in_cs2  = c2q[sent];
        bus3.in_last = lq[sent];
      end
      bus3.out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
      #1;
      if (bus3.out_valid && bus3.out_ready) begin
        check({tag, "_pix"},  int'(bus3.out_pix),  epix[got]);
        check({tag, "_last"}, int'(bus3.out_last), int'(lq[got]));
        got++;
      end
      hold  = bus3.out_valid && !bus3.out_ready;
      hpix  = int'(bus3.out_pix);
      hlast = int'(bus3.out_last);
      if (!bus3.in_ready && blocked == 0) begin
        blocked  = 1;
        buffered = sent - got;
      end
      if (bus3.in_valid && bus3.in_ready) sent++;
      cyc++;
    end
    bus3.in_valid = 1'b0;
    check({tag, "_delivered"}, got, nbeats);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blocked, buffered;

    t3[0] = '{11'd1020, 11'd1020, 1'b1, 1'b0, 255, 0};
    t3[1] = '{11'd12,   11'd0,    1'b0, 1'b0, 2,   0};
    t3[2] = '{11'd6,    11'd5,    1'b1, 1'b0, 1,   0};
    t3[3] = '{11'd2,    11'd1,    1'b0, 1'b0, 0,   0};
    t3[4] = '{11'd3,    11'd1,    1'b1, 1'b0, 1,   0};
    t3[5] = '{11'h03F,  11'h001,  1'b0, 1'b0, 8,   0};
    t3[6] = '{11'd2000, 11'd39,   1'b1, 1'b0, 255, 0};
    t3[7] = '{11'd0,    11'd0,    1'b0, 1'b0, 0,   0};

    t2[0] = '{11'd1020, 11'd1020, 1'b1, 1'b0, 255, 1};
    t2[1] = '{11'd1000, 11'd21,   1'b0, 1'b0, 255, 1};
    t2[2] = '{11'd1000, 11'd22,   1'b1, 1'b0, 255, 2};
    t2[3] = '{11'd0,    11'd5,    1'b0, 1'b0, 1,   2};
    t2[4] = '{11'd1020, 11'd1020, 1'b0, 1'b1, 255, 0};
    t2[5] = '{11'd1020, 11'd1020, 1'b1, 1'b0, 255, 1};

    rst = 1'b1;
    sat_clr3 = 1'b0; sat_clr2 = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_cs1 = '0; bus3.in_cs2 = '0; bus3.in_last = 1'b0;
    bus3.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_cs1 = '0; bus2.in_cs2 = '0; bus2.in_last = 1'b0;
    bus2.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready3",  int'(bus3.in_ready),  1);
    check("rst_in_ready2",  int'(bus2.in_ready),  1);
    check("rst_out_valid3", int'(bus3.out_valid), 0);
    check("rst_out_pix3",   int'(bus3.out_pix),   0);
    check("rst_out_last3",  int'(bus3.out_last),  0);
    check("rst_sat_cnt3",   int'(sat_cnt3),       0);
    check("rst_out_valid2", int'(bus2.out_valid), 0);
    check("rst_sat_cnt2",   int'(sat_cnt2),       0);

    for (int i = 0; i < 8; i++) beat3(t3[i], $sformatf("tbl3_%0d", i));
    for (int i = 0; i < 6; i++) beat2(t2[i], $sformatf("tbl2_%0d", i));

    // Six back-to-back beats with out_ready low for stream cycles 3..7.
    run_stream(6, 1'b0, 3, 7, 100, "bp", blocked, buffered);
    check("bp_in_ready_fell", blocked, 1);
    check("bp_buffered", buffered, 2);

    run_stream(300, 1'b1, 0, 0, 4000, "rnd", blocked, buffered);
    check("rnd_sat_cnt3", int'(sat_cnt3), 0);

    // Reset with two beats in flight; dut2 still holds a nonzero sat count here.
    @(negedge clk);
    bus3.out_ready = 1'b1;
    bus3.in_valid  = 1'b1; bus3.in_cs1 = 11'd500; bus3.in_cs2 = 11'd300; bus3.in_last = 1'b1;
    @(negedge clk);
    bus3.in_cs1 = 11'd200; bus3.in_cs2 = 11'd100; bus3.in_last = 1'b0;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    check("mid_pre_valid", int'(bus3.out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid3", int'(bus3.out_valid), 0);
    check("mid_rst_out_pix3",   int'(bus3.out_pix),   0);
    check("mid_rst_out_last3",  int'(bus3.out_last),  0);
    check("mid_rst_sat_cnt2",   int'(sat_cnt2),       0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready3", int'(bus3.in_ready), 1);
    beat3('{11'd40, 11'd24, 1'b1, 1'b0, 8, 0}, "post_rst");
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_drained", int'(bus3.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
